// File: rtl/mw_writeback_stage_if.sv
// GRF write port and W-stage forwarding bus.
// The write-back stage is the producer; the register file and hazard unit consume it.
interface mw_writeback_stage_if;
    logic        w_we;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] w_pc;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;

    modport master (
        output w_we, w_addr, w_data, w_pc,
        output fwd_valid, fwd_addr, fwd_data
    );

    modport slave (
        input w_we, w_addr, w_data, w_pc,
        input fwd_valid, fwd_addr, fwd_data
    );
endinterface

// File: rtl/mw_writeback_stage.sv
// M/W pipeline register and write-back datapath:
// load extension, write-data select, GRF write port and retire counter.
module mw_writeback_stage #(
    parameter int          RETIRE_W = 32,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m_valid,
    input  logic [31:0]         m_pc,
    input  logic                m_reg_we,
    input  logic [4:0]          m_rd_addr,
    input  logic [1:0]          m_wb_sel,
    input  logic [2:0]          m_load_type,
    input  logic [31:0]         m_alu_res,
    input  logic [31:0]         m_mem_rdata,
    input  logic [31:0]         m_aux_data,
    input  logic                stall,
    input  logic                flush,
    mw_writeback_stage_if.master grf,
    output logic [RETIRE_W-1:0] retire_cnt
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        reg_we;
        logic [4:0]  rd_addr;
        logic [1:0]  wb_sel;
        logic [2:0]  load_type;
        logic [31:0] alu_res;
        logic [31:0] mem_rdata;
        logic [31:0] aux_data;
    } w_reg_t;

    w_reg_t r;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r       <= '0;
            r.pc    <= PC_RESET;
        end else if (!stall) begin
            r.valid     <= m_valid;
            r.pc        <= m_pc;
            r.reg_we    <= m_reg_we;
            r.rd_addr   <= m_rd_addr;
            r.wb_sel    <= m_wb_sel;
            r.load_type <= m_load_type;
            r.alu_res   <= m_alu_res;
            r.mem_rdata <= m_mem_rdata;
            r.aux_data  <= m_aux_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (!flush && !stall && m_valid) begin
            retire_cnt <= retire_cnt + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end
    end

    logic [1:0]  off;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;
    logic [31:0] sel_v;
    logic        is_byte;
    logic        is_half;
    logic        misaligned;
    logic        we;

    always_comb begin
        off     = r.alu_res[1:0];
        byte_v  = r.mem_rdata[{off, 3'b000} +: 8];
        half_v  = off[1] ? r.mem_rdata[31:16] : r.mem_rdata[15:0];
        is_byte = (r.load_type == 3'd1) || (r.load_type == 3'd2);
        is_half = (r.load_type == 3'd3) || (r.load_type == 3'd4);

        unique case (r.load_type)
            3'd1:    load_v = {{24{byte_v[7]}}, byte_v};
            3'd2:    load_v = {24'd0, byte_v};
            3'd3:    load_v = {{16{half_v[15]}}, half_v};
            3'd4:    load_v = {16'd0, half_v};
            default: load_v = r.mem_rdata;
        endcase

        // Alignment only matters for loads; ALU results use bits [1:0] freely.
        misaligned = 1'b0;
        if (r.wb_sel == 2'd1) begin
            if (is_half)       misaligned = off[0];
            else if (!is_byte) misaligned = (off != 2'd0);
        end

        unique case (r.wb_sel)
            2'd0:    sel_v = r.alu_res;
            2'd1:    sel_v = load_v;
            2'd2:    sel_v = r.pc + 32'd8;
            default: sel_v = r.aux_data;
        endcase

        we = r.valid & r.reg_we & (r.rd_addr != 5'd0) & ~misaligned;
    end

    // Zeroing addr/data on no-write keeps forwarding from matching $0 or bubbles.
    assign grf.w_we      = we;
    assign grf.w_addr    = we ? r.rd_addr : 5'd0;
    assign grf.w_data    = we ? sel_v : 32'd0;
    assign grf.w_pc      = r.pc;
    assign grf.fwd_valid = we;
    assign grf.fwd_addr  = we ? r.rd_addr : 5'd0;
    assign grf.fwd_data  = we ? sel_v : 32'd0;

endmodule

// File: doc/mw_writeback_stage.md
Name: mw_writeback_stage

Overview:
- M/W pipeline register plus write-back datapath for the 5-stage core.
- Captures M-stage results and applies load byte/halfword extension.
- Drives the GRF write port (WE, regAddr, regData, pc) and the W-stage forwarding bus.
- Is the producer end of the register-file write interface; also keeps a retired-instruction counter.

Parameters:
RETIRE_W, 32, width of retired-instruction counter
PC_RESET, 32'h0000_3000, value driven on w_pc while stage holds a bubble after reset

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high; clock clk
m_valid  in  1  M stage holds a real instruction
m_pc  in  32  PC of M instruction
m_reg_we  in  1  instruction writes a GPR
m_rd_addr  in  5  destination GPR
m_wb_sel  in  2  0=ALU result, 1=memory load, 2=PC+8, 3=aux (HI/LO/CP0)
m_load_type  in  3  0=lw, 1=lb, 2=lbu, 3=lh, 4=lhu; others treated as lw
m_alu_res  in  32  ALU result; bits [1:0] are load byte offset
m_mem_rdata  in  32  raw word from data memory (little-endian)
m_aux_data  in  32  HI/LO/CP0 read value
stall  in  1  hold W register
flush  in  1  insert bubble into W (exception/eret)
w_we  out  1  GRF write enable
w_addr  out  5  GRF write address
w_data  out  32  GRF write data
w_pc  out  32  PC of W instruction
fwd_valid  out  1  W result forwardable (= w_we)
fwd_addr  out  5  = w_addr
fwd_data  out  32  = w_data
retire_cnt  out  RETIRE_W  count of instructions that entered W

Behaviour:
- Single pipeline register updated on posedge clk. Fields: valid, pc, reg_we, rd_addr, wb_sel, load_type, alu_res, mem_rdata, aux_data.
- Update priority: reset > flush > stall > normal load.
- reset: valid=0, all fields 0, pc=PC_RESET, retire_cnt=0.
  - Outputs after reset: w_we=0, w_addr=0, w_data=0, w_pc=PC_RESET, fwd_valid=0.
- flush: register loads a bubble (valid=0, reg_we=0, other fields 0, pc=PC_RESET). Applies even if stall is high the same cycle.
- stall without flush: register holds its value. Outputs repeat, so a repeated GRF write of the same value is permitted.
- Normal: register captures M inputs; valid=m_valid. Latency 1 cycle: M at edge N appears on w_* after edge N.
- Write-data selection (combinational from the register):
  - wb_sel 0 -> alu_res
  - wb_sel 1 -> extended load
  - wb_sel 2 -> pc+8 (32-bit wrap)
  - wb_sel 3 -> aux_data
- Load extension, off=alu_res[1:0]:
  - lb/lbu: byte mem_rdata[8*off+7:8*off], sign/zero-extended.
  - lh/lhu: halfword mem_rdata[16*off[1]+15:16*off[1]], sign/zero-extended.
  - lw: whole word.
- Misalignment: lh/lhu with off[0]=1, or lw with off!=0, is misaligned. w_we is forced to 0 (M raises AdEL; write must not land).
- w_we = valid & reg_we & (rd_addr!=0) & ~misaligned.
- When w_we=0: w_addr=0 and w_data=0, so forwarding never matches $0 or a bubble.
- w_pc = register pc. Bubble shows PC_RESET after reset/flush, or the held pc during stall.
- retire_cnt: increments by 1 on each edge where the register captures with m_valid=1 (no reset, flush or stall). Wraps modulo 2^RETIRE_W.
  - Counts all instructions, including those with no GPR write (stores, branches).
- Reset mid-stall or mid-flush: reset wins. A register holding a valid instruction is discarded without a write.
- No combinational path from m_* to w_*.

Test Plan:
- Reset: assert reset 2 cycles with m_valid=1 -> w_we=0, w_addr=0, w_data=0, w_pc=32'h3000, retire_cnt=0.
- ALU write: m_valid=1, reg_we=1, rd=5, wb_sel=0, alu_res=32'hDEAD_BEEF, pc=32'h3004 -> next cycle w_we=1, w_addr=5, w_data=32'hDEAD_BEEF, w_pc=32'h3004, retire_cnt=1.
  - Same stimulus with rd=0 -> w_we=0, w_data=0, retire_cnt still increments.
- Load extension, mem_rdata=32'h80FF_7F01:
  - lb off=3 -> 32'hFFFF_FF80
  - lbu off=1 -> 32'h0000_007F
  - lh off=2 -> 32'hFFFF_80FF
  - lhu off=0 -> 32'h0000_7F01
  - lw off=2 -> w_we=0
- jal: wb_sel=2, pc=32'h3010, rd=31 -> w_data=32'h3018, w_addr=31.
  - wb_sel=3, aux=32'h1234 -> w_data=32'h1234.
- Stall/flush: valid write in W, then stall 3 cycles -> outputs constant, retire_cnt unchanged.
  - Then flush+stall together -> next cycle w_we=0, w_pc=32'h3000.
  - Then normal capture resumes with 1-cycle latency.
- Counter wrap: RETIRE_W=4, 17 consecutive valid captures -> retire_cnt=1.
